gf_add_sched: RTL and testbench

Request scheduler for the shared GF(2^233) field adder. Up to NREQ point-arithmetic units (ladder, inversion, squaring control) submit operand pairs; the block arbitrates, drives one shared adder, registers the 233-bit sum, and returns it tagged with the requester ID. One operation is in flight at a time, and a result is held until it is consumed.

---
 rtl/gf233_pkg.sv | 15 +
 rtl/add.sv | 14 +
 rtl/gf_add_sched_arb.sv | 51 +++++
 rtl/gf_add_sched.sv | 124 ++++++++++++
 tb/tb_gf_add_sched.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf233_pkg.sv
// Shared definitions for GF(2^233) datapath blocks: field width, element type,
// scheduler limits and the scheduler state encoding.
package gf233_pkg;

    localparam int GF_WIDTH              = 233;
    localparam int GF_ADD_SCHED_NREQ_MAX = 8;

    typedef logic [GF_WIDTH-1:0] gf233_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } sched_state_t;

endpackage

// File: rtl/add.sv
// GF(2^m) field adder: carry-free, reduction-free bitwise XOR of two elements.
module add
    import gf233_pkg::*;
#(
    parameter int WIDTH = GF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a ^ b;

endmodule

// File: rtl/gf_add_sched_arb.sv
// Combinational one-hot arbiter for gf_add_sched. GF_ADD_SCHED_RR_EN selects
// round-robin starting at ptr; otherwise lowest index wins and ptr is ignored.
module gf_add_sched_arb
    import gf233_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

`ifdef GF_ADD_SCHED_RR_EN
    always_comb begin
        int idx;
        idx      = 0;
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        // Scan NREQ positions starting at ptr; first valid one wins.
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && valid[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && valid[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                grant_id = IDW'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/gf_add_sched.sv
// Scheduler for the shared GF(2^233) adder: arbitrates requesters, registers one
// tagged sum at a time. GF_ADD_SCHED_RR_EN enables round-robin arbitration.
module gf_add_sched
    import gf233_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = GF_WIDTH,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic [15:0]           op_count
);

    sched_state_t     state_reg, state_next;
    logic             ready_en_reg;
    logic             rsp_valid_reg;
    logic [WIDTH-1:0] rsp_data_reg;
    logic [IDW-1:0]   rsp_id_reg;
    logic [15:0]      op_count_reg;

    logic [WIDTH-1:0] a_slice [NREQ];
    logic [WIDTH-1:0] b_slice [NREQ];
    logic [WIDTH-1:0] sum;
    logic [NREQ-1:0]  arb_valid;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   ptr;
    logic             any;
    logic             can_accept;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign a_slice[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_slice[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // ready_en_reg stays low for the first cycle after reset release.
    assign can_accept = ready_en_reg && !rst && ((state_reg == ST_IDLE) || rsp_ready);
    assign arb_valid  = req_valid & {NREQ{can_accept}};
    assign req_ready  = grant;

    gf_add_sched_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .valid    (arb_valid),
        .ptr      (ptr),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any)
    );

    add #(
        .WIDTH (WIDTH)
    ) u_add (
        .a   (a_slice[grant_id]),
        .b   (b_slice[grant_id]),
        .sum (sum)
    );

`ifdef GF_ADD_SCHED_RR_EN
    logic [IDW-1:0] ptr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (any) begin
            ptr_reg <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    assign ptr = ptr_reg;
`else
    assign ptr = '0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (any) state_next = ST_HOLD;
            ST_HOLD: if (rsp_ready && !any) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            ready_en_reg  <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_id_reg    <= '0;
            op_count_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            ready_en_reg  <= 1'b1;
            rsp_valid_reg <= (state_next == ST_HOLD);
            if (any) begin
                rsp_data_reg <= sum;
                rsp_id_reg   <= grant_id;
            end
            if (rsp_valid_reg && rsp_ready) begin
                op_count_reg <= op_count_reg + 16'd1;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_id    = rsp_id_reg;
    assign op_count  = op_count_reg;

endmodule

// File: tb/tb_gf_add_sched.sv
// Self-checking bench for gf_add_sched: directed cases plus randomized traffic,
// scored against a queue-based reference model of the scheduling rules.
module tb_gf_add_sched;

    localparam int NREQ = 4;
    localparam int W    = 233;
    localparam int IDW  = 2;

`ifdef GF_ADD_SCHED_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*W-1:0]     req_a;
    logic [NREQ*W-1:0]     req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [W-1:0]          rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic [15:0]           op_count;

    logic [W-1:0] a_op [NREQ];
    logic [W-1:0] b_op [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_pack
            assign req_a[gi*W +: W] = a_op[gi];
            assign req_b[gi*W +: W] = b_op[gi];
        end
    endgenerate

    gf_add_sched #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           id;
    } exp_t;

    exp_t        exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          holding = 1'b0;
    bit          fresh = 1'b1;
    int          ptr_m = 0;
    logic [15:0] model_ops = 16'd0;
    bit          tally_en = 1'b0;
    bit          verbose = 1'b1;
    int          tally [NREQ];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference arbitration: first valid requester scanning upward from the
    // round-robin pointer (or from 0 in fixed-priority builds), modulo NREQ.
    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        int start;
        start = RR_MODE ? p : 0;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rand_fe();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r[W-1:0];
    endfunction

    // Request-side model: predicts grants, pushes expected results.
    always @(negedge clk) begin
        int g;
        logic [NREQ-1:0] exp_rdy;
        if (rst) begin
            chk("ready_in_reset", 256'(req_ready), 256'(0));
            holding = 1'b0;
            ptr_m   = 0;
            fresh   = 1'b1;
            exp_q.delete();
        end else begin
            g = -1;
            if (!fresh && (!holding || rsp_ready)) g = pick(req_valid, ptr_m);
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 256'(req_ready), 256'(exp_rdy));
            chk("rsp_valid", 256'(rsp_valid), 256'(holding));
            if (g >= 0) begin
                exp_q.push_back('{data: a_op[g] ^ b_op[g], id: g});
                holding = 1'b1;
                ptr_m   = (g + 1) % NREQ;
                if (tally_en) tally[g]++;
            end else if (holding && rsp_ready) begin
                holding = 1'b0;
            end
            fresh = 1'b0;
        end
    end

    // Response-side monitor: compares presented results and the op counter.
    always @(negedge clk) begin
        if (rst) begin
            model_ops = 16'd0;
        end else begin
            chk("op_count", 256'(op_count), 256'(model_ops));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 256'(rsp_valid), 256'(0));
                end else begin
                    chk("rsp_data", 256'(rsp_data), 256'(exp_q[0].data));
                    chk("rsp_id", 256'(rsp_id), 256'(exp_q[0].id));
                    if (rsp_ready) begin
                        if (verbose) $display("rsp id=%0d data=%h ops=%0d", rsp_id, rsp_data, model_ops + 16'd1);
                        void'(exp_q.pop_front());
                        model_ops = model_ops + 16'd1;
                    end
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic random_phase(input int ncyc);
        logic [NREQ-1:0] acc;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    if (req_valid[i]) begin
                        a_op[i] = rand_fe();
                        b_op[i] = rand_fe();
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] first_sum, second_sum, ones, alt;
        bit reached;

        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_op[i] = '0;
            b_op[i] = '0;
            tally[i] = 0;
        end

        // Reset state and single operation
        do_reset();
        chk("reset_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("reset_rsp_data", 256'(rsp_data), 256'(0));
        chk("reset_rsp_id", 256'(rsp_id), 256'(0));
        chk("reset_op_count", 256'(op_count), 256'(0));
        cycle();
        a_op[2]   = W'(1);
        b_op[2]   = W'(3);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("single_ready", 256'(req_ready), 256'(4'b0100));
        cycle();
        req_valid = '0;
        @(negedge clk);
        chk("single_valid", 256'(rsp_valid), 256'(1));
        chk("single_data", 256'(rsp_data), 256'(2));
        chk("single_id", 256'(rsp_id), 256'(2));
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("single_count", 256'(op_count), 256'(1));
        cycle();

        // Backpressure then pass-through
        a_op[0]   = rand_fe();
        b_op[0]   = rand_fe();
        first_sum = a_op[0] ^ b_op[0];
        req_valid = 4'b0001;
        @(negedge clk);
        chk("bp_first_grant", 256'(req_ready), 256'(4'b0001));
        cycle();
        a_op[0]    = rand_fe();
        b_op[0]    = rand_fe();
        second_sum = a_op[0] ^ b_op[0];
        repeat (5) begin
            @(negedge clk);
            chk("bp_ready_low", 256'(req_ready), 256'(0));
            chk("bp_data_frozen", 256'(rsp_data), 256'(first_sum));
            cycle();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_pass_ready", 256'(req_ready), 256'(4'b0001));
        cycle();
        req_valid = '0;
        @(negedge clk);
        chk("bp_valid_kept", 256'(rsp_valid), 256'(1));
        chk("bp_pass_data", 256'(rsp_data), 256'(second_sum));
        cycle();

        // Operand patterns
        ones      = '1;
        a_op[1]   = ones;
        b_op[1]   = ones;
        req_valid = 4'b0010;
        @(negedge clk);
        cycle();
        req_valid = '0;
        @(negedge clk);
        chk("ones_xor_ones", 256'(rsp_data), 256'(0));
        cycle();
        for (int k = 0; k < W; k++) alt[k] = (k % 2 == 0);
        a_op[3]   = alt;
        b_op[3]   = ~alt;
        req_valid = 4'b1000;
        @(negedge clk);
        cycle();
        req_valid = '0;
        @(negedge clk);
        chk("alt_xor", 256'(rsp_data), 256'(ones));
        chk("alt_bit232", 256'(rsp_data[232]), 256'(1));
        cycle();

        // Randomized traffic
        random_phase(300);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) cycle();

        // Fairness / fixed priority with all requesters active
        do_reset();
        cycle();
        for (int i = 0; i < NREQ; i++) begin
            a_op[i]  = rand_fe();
            b_op[i]  = rand_fe();
            tally[i] = 0;
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        tally_en  = 1'b1;
        repeat (100) cycle();
        tally_en  = 1'b0;
        req_valid = '0;
        cycle();
        @(negedge clk);
        chk("burst_op_count", 256'(op_count), 256'(100));
        for (int i = 0; i < NREQ; i++) begin
            chk($sformatf("grants_req%0d", i), 256'(tally[i]),
                256'(RR_MODE ? 25 : ((i == 0) ? 100 : 0)));
        end
        cycle();

        // Counter wrap
        do_reset();
        cycle();
        verbose   = 1'b0;
        a_op[0]   = rand_fe();
        b_op[0]   = rand_fe();
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        reached   = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            cycle();
            if (model_ops == 16'hFFFF) begin
                reached = 1'b1;
                break;
            end
        end
        chk("wrap_reached", 256'(reached), 256'(1));
        chk("wrap_ffff", 256'(op_count), 256'(16'hFFFF));
        cycle();
        chk("wrap_zero", 256'(op_count), 256'(0));
        cycle();
        verbose = 1'b1;

        // Asynchronous reset while a result is held
        rsp_ready = 1'b0;
        cycle();
        cycle();
        @(negedge clk);
        chk("hold_before_rst", 256'(rsp_valid), 256'(1));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 256'(rsp_valid), 256'(0));
        chk("async_rst_count", 256'(op_count), 256'(0));
        chk("async_rst_ready", 256'(req_ready), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;

        // More random traffic after reset, then drain
        random_phase(150);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) cycle();
        @(negedge clk);
        chk("drain_empty", 256'(exp_q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
